bus_ram_arb: RTL and testbench

//  Parametrised successor of the 8 KB CPU RAM: one inferred single-port RAM shared by the
//  CPU (req/ack handshake on the tri-state data_bus) and the video fetcher (read-only port).
//  Per-cycle arbitration of the single RAM issue slot, video always wins.
//  CPU wait states cover contention, configurable read latency and extra wait cycles.

---
 rtl/bus_ram_pkg.sv | 19 +
 rtl/bus_ram_arb_ram.sv | 43 ++++
 rtl/bus_ram_arb.sv | 160 ++++++++++++++++
 tb/tb_bus_ram_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ram_pkg.sv
// Shared definitions for the CPU/video RAM arbiter.
//  - FSM state encodings for the CPU handshake (IDLE / WAITLAT / HOLD)
//  - CPU_WAIT_MAX: largest number of extra CPU wait cycles supported
//  - read_lat_legal(): legality check for the RAM read latency parameter
package bus_ram_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WAITLAT = 2'd1;
  localparam state_t ST_HOLD    = 2'd2;

  localparam int CPU_WAIT_MAX = 7;

  function automatic bit read_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/bus_ram_arb_ram.sv
// sp_ram_infer: inferred single-port block RAM.
//  clk  in   rising-edge clock
//  ce   in   access enable for this cycle
//  wre  in   1 = write din to ad, 0 = read ad
//  ad   in   word address
//  din  in   write data
//  dout out  read data, READ_LAT cycles after a read is issued; unchanged by writes
// READ_LAT = 2 adds an output register behind the array read register.
module sp_ram_infer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 13,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] dout_p0;

  always_ff @(posedge clk) begin
    if (ce) begin
      if (wre) mem[ad] <= din;
      else     dout_p0 <= mem[ad];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_oreg
      logic [DATA_W-1:0] dout_p1;
      // ---- stage p0 -> p1: optional output register ----
      always_ff @(posedge clk) dout_p1 <= dout_p0;
      assign dout = dout_p1;
    end else begin : g_noreg
      assign dout = dout_p0;
    end
  endgenerate

endmodule

// File: rtl/bus_ram_arb.sv
// bus_ram_arb: single-port RAM shared by the CPU (req/ack on a tri-state data bus)
// and a read-only video fetcher. One RAM access per cycle; video always wins the slot.
//  clk       in     rising-edge clock
//  reset     in     synchronous active-high; RAM contents are kept
//  cpu_req   in     level request, held with cpu_ad/cpu_wre/write data until cpu_ack
//  cpu_wre   in     1 = write, 0 = read
//  cpu_ad    in     CPU word address
//  data_bus  inout  write data in; read data out while cpu_oe = 1
//  cpu_ack   out    one-cycle completion pulse
//  cpu_wait  out    CPU WAIT line: request pending and not yet acked
//  cpu_oe    out    block is driving data_bus
//  vid_req   in     one-cycle video read request
//  vid_ad    in     video word address
//  vid_dout  out    video read data, held between vid_valid pulses
//  vid_valid out    pulse READ_LAT cycles after vid_req
module bus_ram_arb
  import bus_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 13,
  parameter int READ_LAT = 1,
  parameter int CPU_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wre,
  input  logic [ADDR_W-1:0] cpu_ad,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic              cpu_oe,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_ad,
  output logic [DATA_W-1:0] vid_dout,
  output logic              vid_valid
);

  generate
    if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
      $error("bus_ram_arb: READ_LAT must be 1 or 2");
    end
    if (CPU_WAIT < 0 || CPU_WAIT > CPU_WAIT_MAX) begin : g_bad_cpu_wait
      $error("bus_ram_arb: CPU_WAIT out of range 0..7");
    end
  endgenerate

  // Wide enough for the largest (READ_LAT + CPU_WAIT - 1) = 8.
  localparam int CNT_W = 4;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              vid_issue;
  logic              cpu_issue;
  logic              ram_ce;
  logic              ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_dout;
  logic              vid_vld_p0;
  logic              vid_vld_p1;
  logic              rd_tag_p0;
  logic              rd_tag_p1;
  logic              rd_tag_out;
  logic [DATA_W-1:0] rd_latch;
  logic [DATA_W-1:0] vid_hold;

  // Cycles from issue to cpu_ack, minus one (the counter reaches zero on the ack cycle).
  function automatic logic [CNT_W-1:0] ack_count(input logic wre);
    int lat;
    lat = (wre ? 1 : READ_LAT) + CPU_WAIT - 1;
    return CNT_W'(lat);
  endfunction

  // Arbitration: video takes the slot whenever it asks; the CPU only gets a free cycle.
  // Nothing is issued while reset is asserted so an aborted write cannot land.
  assign vid_issue = vid_req & ~reset;
  assign cpu_issue = (state == ST_IDLE) & cpu_req & ~vid_req & ~reset;
  assign ram_ce    = vid_issue | cpu_issue;
  assign ram_wre   = cpu_issue & cpu_wre;
  assign ram_ad    = vid_req ? vid_ad : cpu_ad;

  sp_ram_infer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT)
  ) u_ram (
    .clk  (clk),
    .ce   (ram_ce),
    .wre  (ram_wre),
    .ad   (ram_ad),
    .din  (data_bus),
    .dout (ram_dout)
  );

  // CPU handshake outputs are combinational on cpu_req so the bus is released
  // in the very cycle the CPU drops its request.
  assign cpu_ack  = (state == ST_WAITLAT) & (wait_cnt == '0) & cpu_req;
  assign cpu_wait = cpu_req & ~cpu_ack & (state != ST_HOLD);
  assign cpu_oe   = (state == ST_HOLD) & cpu_req & ~cpu_wre;
  assign data_bus = cpu_oe ? rd_latch : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_issue) begin
            state    <= ST_WAITLAT;
            wait_cnt <= ack_count(cpu_wre);
          end
        end
        ST_WAITLAT: begin
          // A dropped request abandons the access; a write has already been committed.
          if (!cpu_req)              state    <= ST_IDLE;
          else if (wait_cnt == '0)   state    <= ST_HOLD;
          else                       wait_cnt <= wait_cnt - CNT_W'(1);
        end
        ST_HOLD: begin
          if (!cpu_req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: issue tags travel with the RAM read pipeline ----
  // Video may reuse the RAM output while the CPU sits in its extra wait cycles,
  // so the CPU read is captured when its own tag emerges, not at ack time.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_vld_p0 <= 1'b0;
      vid_vld_p1 <= 1'b0;
      rd_tag_p0  <= 1'b0;
      rd_tag_p1  <= 1'b0;
    end else begin
      vid_vld_p0 <= vid_issue;
      vid_vld_p1 <= vid_vld_p0;
      rd_tag_p0  <= cpu_issue & ~cpu_wre;
      rd_tag_p1  <= rd_tag_p0;
    end
  end

  assign vid_valid  = (READ_LAT == 2) ? vid_vld_p1 : vid_vld_p0;
  assign rd_tag_out = (READ_LAT == 2) ? rd_tag_p1  : rd_tag_p0;

  // ---- output stage: CPU read latch and video hold register ----
  always_ff @(posedge clk) begin
    if (rd_tag_out) rd_latch <= ram_dout;
  end

  always_ff @(posedge clk) begin
    if (reset)          vid_hold <= '0;
    else if (vid_valid) vid_hold <= ram_dout;
  end

  assign vid_dout = vid_valid ? ram_dout : vid_hold;

endmodule

// File: tb/tb_bus_ram_arb.sv
// Self-checking bench for bus_ram_arb (READ_LAT = 2, CPU_WAIT = 3).
// The driver plays CPU and video traffic cycle by cycle, keeps a plain array model of
// RAM contents, and pushes the expected per-cycle CPU handshake and expected video
// returns into queues; a negedge monitor pops and compares.
module tb_bus_ram_arb;

  localparam int DW = 8;
  localparam int AW = 13;
  localparam int RL = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_wre = 1'b0;
  logic [AW-1:0] cpu_ad = '0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_ad = '0;
  logic          drv_en = 1'b0;
  logic [DW-1:0] drv_val = '0;
  wire  [DW-1:0] data_bus;
  logic          cpu_ack, cpu_wait, cpu_oe, vid_valid;
  logic [DW-1:0] vid_dout;

  always #5 clk = ~clk;

  assign data_bus = drv_en ? drv_val : {DW{1'bz}};

  bus_ram_arb #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL), .CPU_WAIT(CW)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wre(cpu_wre), .cpu_ad(cpu_ad),
    .data_bus(data_bus), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .cpu_oe(cpu_oe),
    .vid_req(vid_req), .vid_ad(vid_ad), .vid_dout(vid_dout), .vid_valid(vid_valid)
  );

  typedef struct { int c; logic [DW-1:0] d; } vexp_t;
  typedef struct { int c; bit chk; bit ack; bit wt; bit oe; logic [DW-1:0] bus; } cexp_t;

  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  vexp_t vid_q[$];
  cexp_t ctl_q[$];
  vexp_t ve_m;
  cexp_t ce_m;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  logic [DW-1:0] last_vdata = '0;
  bit clr_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(127));
  endfunction

  // One clock cycle of stimulus plus the expected CPU handshake for that cycle.
  task automatic tick(input bit rs, input bit rq, input bit we, input logic [AW-1:0] ad,
                      input logic [DW-1:0] wd, input bit vr, input logic [AW-1:0] va,
                      input bit chk, input bit e_ack, input bit e_wait, input bit e_oe,
                      input logic [DW-1:0] e_bus);
    @(posedge clk);
    #1;
    cyc++;
    reset   = rs;
    cpu_req = rq;
    cpu_wre = we;
    cpu_ad  = ad;
    drv_val = wd;
    drv_en  = rq & we;
    vid_req = vr;
    vid_ad  = va;
    if (rs) begin
      while (vid_q.size() > 0 && vid_q[vid_q.size()-1].c > cyc) void'(vid_q.pop_back());
    end else if (vr) begin
      vid_q.push_back('{cyc + RL, mem_m[va]});
    end
    ctl_q.push_back('{cyc, chk, e_ack, e_wait, e_oe, e_bus});
  endtask

  // One CPU access with optional video traffic.
  //  pct      : percent chance of a random video read in any cycle
  //  burst    : leading cycles with forced video reads at bbase, bbase+1, ...
  //  hold_vid : force a video read of bbase in the cycle after the ack
  //  stop_k   : 0 = run to completion, else end the access k cycles after issue
  //  stop_rst : end it with reset instead of dropping cpu_req
  task automatic cpu_txn(input bit wre, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         input int pct, input int burst, input logic [AW-1:0] bbase,
                         input bit hold_vid, input int stop_k, input bit stop_rst);
    int L;
    int n;
    bit vr;
    bit issued;
    logic [AW-1:0] va;
    logic [DW-1:0] rd;
    L = (wre ? 1 : RL) + CW;
    n = 0;
    rd = '0;
    issued = 1'b0;
    while (!issued) begin
      if (n < burst) begin vr = 1'b1; va = bbase + AW'(n); end
      else begin vr = ($urandom_range(99) < pct); va = rnd_addr(); end
      tick(0, 1, wre, ad, wd, vr, va, 1, 0, 1, 0, '0);
      n++;
      issued = !vr;
    end
    if (wre) mem_m[ad] = wd;
    else     rd = mem_m[ad];
    for (int k = 1; k <= L + 1; k++) begin
      vr = ($urandom_range(99) < pct);
      va = rnd_addr();
      if (k == L + 1 && hold_vid) begin vr = 1'b1; va = bbase; end
      if (k == stop_k) begin
        if (stop_rst) begin
          tick(1, 1, wre, ad, wd, vr, va, 0, 0, 0, 0, '0);
          tick(0, 0, wre, ad, wd, 0, va, 1, 0, 0, 0, '0);
        end else begin
          tick(0, 0, wre, ad, wd, vr, va, 1, 0, 0, 0, '0);
        end
        return;
      end
      if (k < L)       tick(0, 1, wre, ad, wd, vr, va, 1, 0, 1, 0, '0);
      else if (k == L) tick(0, 1, wre, ad, wd, vr, va, 1, 1, 0, 0, '0);
      else             tick(0, 1, wre, ad, wd, vr, va, 1, 0, 0, !wre, rd);
    end
    vr = ($urandom_range(99) < pct);
    tick(0, 0, wre, ad, wd, vr, rnd_addr(), 1, 0, 0, 0, '0);
  endtask

  // Monitor: compares DUT outputs against whatever the driver queued for this cycle.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      if (ctl_q.size() > 0 && ctl_q[0].c == cyc) begin
        ce_m = ctl_q.pop_front();
        if (ce_m.chk) begin
          check("cpu_ack", 32'(cpu_ack), 32'(ce_m.ack));
          check("cpu_wait", 32'(cpu_wait), 32'(ce_m.wt));
          check("cpu_oe", 32'(cpu_oe), 32'(ce_m.oe));
          if (ce_m.oe) check("cpu_rdata", 32'(data_bus), 32'(ce_m.bus));
        end
      end
      if (!reset && clr_pend) begin
        last_vdata = '0;
        clr_pend = 1'b0;
      end
      if (vid_valid) begin
        if (vid_q.size() == 0) begin
          check("vid_spurious", 32'(vid_valid), 32'(0));
        end else begin
          ve_m = vid_q.pop_front();
          check("vid_time", 32'(cyc), 32'(ve_m.c));
          check("vid_data", 32'(vid_dout), 32'(ve_m.d));
          last_vdata = ve_m.d;
        end
      end else begin
        if (vid_q.size() > 0 && vid_q[0].c <= cyc) begin
          ve_m = vid_q.pop_front();
          check("vid_missing", 32'(vid_valid), 32'(1));
        end
        if (!reset) check("vid_hold", 32'(vid_dout), 32'(last_vdata));
      end
      if (reset) clr_pend = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int L_rd;
    L_rd = RL + CW;
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;

    // reset, then check idle outputs
    for (int i = 0; i < 3; i++) tick(1, 0, 0, '0, '0, 0, '0, 0, 0, 0, 0, '0);
    tick(0, 0, 0, '0, '0, 0, '0, 1, 0, 0, 0, '0);
    tick(0, 0, 0, '0, '0, 0, '0, 1, 0, 0, 0, '0);

    // write 0xA5 @0x0123 then read it back, no video traffic
    cpu_txn(1, AW'(13'h0123), 8'hA5, 0, 0, '0, 0, 0, 0);
    cpu_txn(0, AW'(13'h0123), 8'h00, 0, 0, '0, 0, 0, 0);

    // preload 0..127
    for (int a = 0; a < 128; a++) cpu_txn(1, AW'(a), DW'($urandom), 0, 0, '0, 0, 0, 0);

    // 8-cycle video burst on 0..7 while a CPU read waits
    cpu_txn(0, AW'(13'h0123), 8'h00, 0, 8, AW'(0), 0, 0, 0);

    // same-cycle CPU write / video read @0x40, then video read right after the ack
    cpu_txn(1, AW'(13'h0040), 8'h3C, 0, 1, AW'(13'h0040), 1, 0, 0);

    // abort a write (data still lands) and a read (no ack, bus not driven)
    cpu_txn(1, AW'(7), 8'h5A, 0, 0, '0, 0, 1, 0);
    cpu_txn(0, AW'(7), 8'h00, 0, 0, '0, 0, 0, 0);
    cpu_txn(0, AW'(8), 8'h00, 0, 0, '0, 0, 3, 0);

    // reset in WAITLAT and in HOLD, with video traffic around it
    cpu_txn(0, AW'(5), 8'h00, 50, 0, '0, 0, 2, 1);
    cpu_txn(0, AW'(6), 8'h00, 50, 0, '0, 0, L_rd + 1, 1);
    cpu_txn(0, AW'(6), 8'h00, 0, 0, '0, 0, 0, 0);

    // randomized mix
    for (int i = 0; i < 120; i++) begin
      bit w;
      int sk;
      bit sr;
      w  = 1'($urandom_range(1));
      sk = 0;
      sr = 1'b0;
      if ($urandom_range(9) == 0) begin
        sk = $urandom_range((w ? 1 : RL) + CW, 1);
        sr = ($urandom_range(3) == 0);
      end
      cpu_txn(w, rnd_addr(), DW'($urandom), $urandom_range(60), $urandom_range(3),
              AW'($urandom_range(120)), 1'($urandom_range(1)), sk, sr);
    end

    // back-to-back video sweep: RAM contents must match the model after all resets
    for (int a = 0; a < 128; a++) tick(0, 0, 0, '0, '0, 1, AW'(a), 1, 0, 0, 0, '0);
    tick(0, 0, 0, '0, '0, 1, AW'(13'h0123), 1, 0, 0, 0, '0);
    for (int i = 0; i < RL + 3; i++) tick(0, 0, 0, '0, '0, 0, '0, 1, 0, 0, 0, '0);
    @(negedge clk);
    @(negedge clk);
    check("vid_q_drained", 32'(vid_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
